// File: rtl/call_register_if.sv
// Bundles the buttons, serve strobe and call outputs of the call register.
// The slave modport is the call register itself; the master modport is the
// controller or bench that drives buttons and serve strobes.
interface call_register_if #(
    parameter int FLOORS = 8
);
    logic [FLOORS-1:0] btn_cab;
    logic [FLOORS-2:0] btn_up;
    logic [FLOORS-1:1] btn_down;
    logic [3:0]        current_floor;
    logic              serve_valid;
    logic [3:0]        serve_floor;
    logic [1:0]        serve_dir;
    logic [FLOORS-1:0] cab_calls;
    logic [FLOORS-2:0] up_calls;
    logic [FLOORS-1:1] down_calls;
    logic              call_above;
    logic              call_below;
    logic              call_here;
    logic              any_call;

    modport master (
        output btn_cab, btn_up, btn_down, current_floor,
        output serve_valid, serve_floor, serve_dir,
        input  cab_calls, up_calls, down_calls,
        input  call_above, call_below, call_here, any_call
    );

    modport slave (
        input  btn_cab, btn_up, btn_down, current_floor,
        input  serve_valid, serve_floor, serve_dir,
        output cab_calls, up_calls, down_calls,
        output call_above, call_below, call_here, any_call
    );
endinterface

// File: rtl/call_register.sv
// Elevator call register: synchronises and debounces cabin and hall buttons,
// turns accepted presses into pending call bits, clears them on serve
// strobes and summarises pending calls relative to the cabin position.
//
// Serve handshake: serve_valid is a one-cycle strobe with no ready/back-
// pressure; it is always consumed on the edge where it is sampled high.
// A strobe naming a floor outside 0..FLOORS-1 is dropped. On the same bit a
// serve clear wins over a press event, and the press is lost.
module call_register #(
    parameter int FLOORS    = 8,
    parameter int DEBOUNCE  = 4,
    parameter int CANCEL_EN = 1
) (
    input  logic            clock,
    input  logic            an_reset,
    call_register_if.slave  bus
);

    // Flattened button layout: cabin [F-1:0], up [2F-2:F], down [3F-3:2F-1].
    localparam int NB     = 3 * FLOORS - 2;
    localparam int UP_LO  = FLOORS;
    localparam int DN_OFF = 2 * FLOORS - 2;

    logic [NB-1:0]     raw;
    logic [NB-1:0]     sync1_q;
    logic [NB-1:0]     sync2_q;
    logic [NB-1:0]     acc_q;
    logic [NB-1:0]     acc_prev_q;
    logic [7:0]        cnt_q [NB];
    logic [NB-1:0]     press;

    logic [FLOORS-1:0] cab_q;
    logic [FLOORS-1:0] cab_d;
    logic [FLOORS-2:0] up_q;
    logic [FLOORS-2:0] up_d;
    logic [FLOORS-1:1] down_q;
    logic [FLOORS-1:1] down_d;

    logic              serve_hit;
    logic              floor_ok;
    logic [FLOORS-1:0] pend;
    logic              above;
    logic              below;
    logic              here;

    assign raw = {bus.btn_down, bus.btn_up, bus.btn_cab};

    // Two-flop synchroniser on every raw button bit.
    always_ff @(posedge clock or negedge an_reset) begin
        if (!an_reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Per-button debounce: count cycles the synchronised level disagrees
    // with the accepted level; adopt it once the count reaches DEBOUNCE.
    always_ff @(posedge clock or negedge an_reset) begin
        if (!an_reset) begin
            acc_q      <= '0;
            acc_prev_q <= '0;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            acc_prev_q <= acc_q;
            for (int i = 0; i < NB; i++) begin
                if (sync2_q[i] == acc_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == 8'(DEBOUNCE - 1)) begin
                    acc_q[i] <= sync2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 8'd1;
                end
            end
        end
    end

    // One-cycle press event on each rising edge of an accepted level.
    assign press = acc_q & ~acc_prev_q;

    assign serve_hit = bus.serve_valid && ({1'b0, bus.serve_floor} < 5'(FLOORS));

    // Next call state: press sets (cabin may toggle), serve clear overrides.
    always_comb begin
        cab_d  = cab_q;
        up_d   = up_q;
        down_d = down_q;
        for (int f = 0; f < FLOORS; f++) begin
            if (press[f]) begin
                if (!cab_q[f]) begin
                    cab_d[f] = 1'b1;
                end else if (CANCEL_EN != 0) begin
                    cab_d[f] = 1'b0;
                end
            end
            if (serve_hit && (bus.serve_floor == 4'(f))) begin
                cab_d[f] = 1'b0;
            end
        end
        for (int f = 0; f < FLOORS - 1; f++) begin
            if (press[UP_LO + f]) begin
                up_d[f] = 1'b1;
            end
            if (serve_hit && bus.serve_dir[0] && (bus.serve_floor == 4'(f))) begin
                up_d[f] = 1'b0;
            end
        end
        for (int f = 1; f < FLOORS; f++) begin
            if (press[DN_OFF + f]) begin
                down_d[f] = 1'b1;
            end
            if (serve_hit && bus.serve_dir[1] && (bus.serve_floor == 4'(f))) begin
                down_d[f] = 1'b0;
            end
        end
    end

    // Registered pending call vectors.
    always_ff @(posedge clock or negedge an_reset) begin
        if (!an_reset) begin
            cab_q  <= '0;
            up_q   <= '0;
            down_q <= '0;
        end else begin
            cab_q  <= cab_d;
            up_q   <= up_d;
            down_q <= down_d;
        end
    end

    // Per-floor pending flag merged from all three call vectors.
    always_comb begin
        pend                = cab_q;
        pend[FLOORS-2:0]    = pend[FLOORS-2:0] | up_q;
        pend[FLOORS-1:1]    = pend[FLOORS-1:1] | down_q;
    end

    assign floor_ok = {1'b0, bus.current_floor} < 5'(FLOORS);

    // Direction summary relative to the cabin; silent when off the shaft.
    always_comb begin
        above = 1'b0;
        below = 1'b0;
        here  = 1'b0;
        if (floor_ok) begin
            for (int f = 0; f < FLOORS; f++) begin
                if (f > int'(bus.current_floor)) begin
                    above = above | pend[f];
                end else if (f < int'(bus.current_floor)) begin
                    below = below | pend[f];
                end else begin
                    here = here | pend[f];
                end
            end
        end
    end

    assign bus.cab_calls  = cab_q;
    assign bus.up_calls   = up_q;
    assign bus.down_calls = down_q;
    assign bus.call_above = above;
    assign bus.call_below = below;
    assign bus.call_here  = here;
    assign bus.any_call   = |pend;

endmodule
